uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between two byte producers.
  - Requester 0: the core's output stream.
  - Requester 1: the debug/status channel.
- Each requester uses a valid/ready byte handshake. The arbiter serialises accepted bytes into the transmitter's start/busy interface.
- Supports packet locking so that a multi-byte message from one requester is never interleaved with bytes from the other.

---
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between two byte producers. Each producer uses
// a valid/ready byte handshake. Accepted bytes go to the transmitter through a
// one-cycle start pulse, and the block then tracks the transmitter's busy line.
// A byte with last=0 locks the arbiter to its producer until that producer
// sends a byte with last=1, so packets are never interleaved.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   reqN_valid/data/last  producer N byte offer (N = 0 core, 1 debug)
//   reqN_ready          combinational accept for producer N
//   tx_data, tx_start   registered byte and one-cycle start pulse to the transmitter
//   tx_busy             transmitter busy
//   grant               one-hot current owner, 00 when idle and unlocked
//   err_timeout         sticky: the transmitter never raised busy after a start
module uart_tx_arbiter #(
  parameter int PRIO_MODE   = 0,  // 0 round-robin between packets, 1 requester 0 wins
  parameter int ACK_TIMEOUT = 4   // 1..255 cycles to wait for tx_busy after a start
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       err_timeout
);

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state_q;
  logic       lock_q;      // a packet is open
  logic       owner_q;     // requester holding the lock
  logic       rr_last_q;   // requester served by the most recently completed packet
  logic [7:0] tx_data_q;
  logic       tx_start_q;
  logic [1:0] grant_q;
  logic       err_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  logic       winner;
  logic       can_acc;
  logic       hs;
  logic       hs_last;
  logic [7:0] hs_data;
  logic [1:0] idle_grant;

  // Winner is only consulted in IDLE. When locked, the owner is the only
  // candidate even with its valid low, which stalls the other requester.
  always_comb begin
    winner = 1'b0;
    if (lock_q)                       winner = owner_q;
    else if (req0_valid && req1_valid) winner = (PRIO_MODE != 0) ? 1'b0 : ~rr_last_q;
    else if (req1_valid)              winner = 1'b1;
  end

  assign can_acc    = (state_q == IDLE) && !tx_busy;
  assign req0_ready = can_acc && !winner && req0_valid;
  assign req1_ready = can_acc &&  winner && req1_valid;
  assign hs         = req0_ready || req1_ready;
  assign hs_last    = winner ? req1_last : req0_last;
  assign hs_data    = winner ? req1_data : req0_data;
  assign cnt_d      = cnt_q + 8'd1;

  // Grant shown once back in IDLE: the owner while a packet is open, else none.
  assign idle_grant = lock_q ? {owner_q, ~owner_q} : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_q     <= 1'b0;
      owner_q    <= 1'b0;
      rr_last_q  <= 1'b1;  // requester 0 wins the first tie
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      grant_q    <= 2'b00;
      err_q      <= 1'b0;
      cnt_q      <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            tx_data_q  <= hs_data;
            tx_start_q <= 1'b1;
            grant_q    <= {winner, ~winner};
            state_q    <= START;
            if (!hs_last) begin
              lock_q  <= 1'b1;
              owner_q <= winner;
            end else begin
              lock_q    <= 1'b0;
              rr_last_q <= winner;
            end
          end
        end
        START: begin
          tx_start_q <= 1'b0;
          cnt_q      <= 8'h00;
          state_q    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == TO_LAST) begin
            // Byte is dropped; an open packet stays locked.
            err_q   <= 1'b1;
            grant_q <= idle_grant;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            grant_q <= idle_grant;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign grant       = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_last = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req0_ready, req1_ready, tx_start, err_timeout;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic       tx_busy;
  logic       p1_req0_ready, p1_req1_ready, p1_tx_start, p1_err_timeout;
  logic [7:0] p1_tx_data;
  logic [1:0] p1_grant;

  logic busy_model = 1'b0;
  logic busy_force = 1'b0;
  logic tx_auto    = 1'b1;
  int   bcnt       = 0;
  int   ncmp       = 0;
  int   nfail      = 0;

  assign tx_busy = busy_model | busy_force;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.PRIO_MODE(0), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant(grant), .err_timeout(err_timeout)
  );

  // Fixed-priority instance sharing the stimulus; only compared in the tie test.
  uart_tx_arbiter #(.PRIO_MODE(1), .ACK_TIMEOUT(4)) dut_p1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(p1_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(p1_req1_ready),
    .tx_data(p1_tx_data), .tx_start(p1_tx_start), .tx_busy(tx_busy),
    .grant(p1_grant), .err_timeout(p1_err_timeout)
  );

  // Transmitter model: busy for 10 cycles starting the cycle after tx_start.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bcnt = 0;
        busy_model = 1'b0;
      end else begin
        if (bcnt > 0) begin
          busy_model = 1'b1;
          bcnt--;
        end else begin
          busy_model = 1'b0;
        end
        if (tx_auto && tx_start) bcnt = 10;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advances to the next tx_start (bounded) and checks the byte sent.
  task automatic wait_start(input string tag, input logic [7:0] exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < 40);
    chk({tag, "_start"}, {31'd0, tx_start}, 32'd1);
    chk({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp});
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    int viol;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    rst = 1'b0;

    // Single byte, then a second byte held valid during the frame
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h41; req0_last = 1'b1;
    #1;
    chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t1_ready1", {31'd0, req1_ready}, 32'd0);
    chk("t1_grant_idle", {30'd0, grant}, 32'd0);
    @(negedge clk);
    chk("t1_start", {31'd0, tx_start}, 32'd1);
    chk("t1_data", {24'd0, tx_data}, 32'h41);
    chk("t1_grant", {30'd0, grant}, 32'd1);
    req0_data = 8'h42;
    @(negedge clk);
    chk("t1_pulse_len", {31'd0, tx_start}, 32'd0);
    viol = (req0_ready || tx_data != 8'h41) ? 1 : 0;
    for (int k = 2; k <= 11; k++) begin
      @(negedge clk);
      if (req0_ready || tx_start) viol++;
    end
    chk("t1_no_ready_busy", viol, 0);
    @(negedge clk);
    chk("t1_ready_after", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    chk("t1_b2b_start", {31'd0, tx_start}, 32'd1);
    chk("t1_b2b_data", {24'd0, tx_data}, 32'h42);
    drain();

    // Tie: round-robin on dut, fixed priority on dut_p1
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h10; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h20; req1_last = 1'b1;
    wait_start("tie1", 8'h10);
    chk("tie1_p1_start", {31'd0, p1_tx_start}, 32'd1);
    chk("tie1_p1_data", {24'd0, p1_tx_data}, 32'h10);
    wait_start("tie2", 8'h20);
    chk("tie2_p1_start", {31'd0, p1_tx_start}, 32'd1);
    chk("tie2_p1_data", {24'd0, p1_tx_data}, 32'h10);
    wait_start("tie3", 8'h10);
    chk("tie3_p1_start", {31'd0, p1_tx_start}, 32'd1);
    chk("tie3_p1_data", {24'd0, p1_tx_data}, 32'h10);
    drain();

    // Packet lock from req1 with req0 waiting; req1 served last is req0 -> req1 wins
    req0_valid = 1'b1; req0_data = 8'h55; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 8'hA0; req1_last = 1'b0;
    #1;
    chk("lk_ready1", {31'd0, req1_ready}, 32'd1);
    chk("lk_ready0", {31'd0, req0_ready}, 32'd0);
    wait_start("lkA0", 8'hA0);
    chk("lkA0_grant", {30'd0, grant}, 32'd2);
    req1_valid = 1'b0;
    viol = 0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (req0_ready || tx_start || grant != 2'b10) viol++;
    end
    chk("lk_gap", viol, 0);
    req1_valid = 1'b1; req1_data = 8'hA1; req1_last = 1'b0;
    wait_start("lkA1", 8'hA1);
    chk("lkA1_grant", {30'd0, grant}, 32'd2);
    req1_data = 8'hA2; req1_last = 1'b1;
    wait_start("lkA2", 8'hA2);
    chk("lkA2_grant", {30'd0, grant}, 32'd2);
    req1_valid = 1'b0;
    wait_start("lk_r0", 8'h55);
    chk("lk_r0_grant", {30'd0, grant}, 32'd1);
    drain();
    chk("lk_grant_end", {30'd0, grant}, 32'd0);

    // Ack timeout
    tx_auto = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h77; req0_last = 1'b1;
    wait_start("to", 8'h77);
    req0_valid = 1'b0;
    viol = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (err_timeout) viol++;
    end
    chk("to_early", viol, 0);
    @(negedge clk);
    chk("to_err", {31'd0, err_timeout}, 32'd1);
    chk("to_grant", {30'd0, grant}, 32'd0);
    tx_auto = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h99; req1_last = 1'b1;
    #1;
    chk("to_ready_next", {31'd0, req1_ready}, 32'd1);
    wait_start("to_next", 8'h99);
    drain();
    chk("to_sticky", {31'd0, err_timeout}, 32'd1);

    // Async reset in WAIT_DONE with an open packet
    req0_valid = 1'b1; req0_data = 8'h33; req0_last = 1'b0;
    wait_start("ar", 8'h33);
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("ar_busy", {31'd0, tx_busy}, 32'd1);
    chk("ar_grant_pre", {30'd0, grant}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("ar_start", {31'd0, tx_start}, 32'd0);
    chk("ar_grant", {30'd0, grant}, 32'd0);
    chk("ar_data", {24'd0, tx_data}, 32'd0);
    chk("ar_err", {31'd0, err_timeout}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    req1_valid = 1'b1; req1_data = 8'h5A; req1_last = 1'b1;
    rst = 1'b0;
    #1;
    chk("ar_ready1", {31'd0, req1_ready}, 32'd1);
    wait_start("ar_next", 8'h5A);
    chk("ar_next_grant", {30'd0, grant}, 32'd2);
    drain();

    // Busy while idle
    busy_force = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h6B; req0_last = 1'b1;
    viol = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req0_ready || tx_start) viol++;
    end
    chk("bi_no_ready", viol, 0);
    busy_force = 1'b0;
    #1;
    chk("bi_ready", {31'd0, req0_ready}, 32'd1);
    wait_start("bi", 8'h6B);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
